// File: rtl/trap_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// trap_sequencer_pkg
// Shared types and constants for the trap sequencer and its target
// calculator:
//   program_state_t : privilege level plus interrupt-enable stack
//   trap_kind_t     : request kind presented by commit
//   PRIV_U/S/M      : privilege encodings
//   CAUSE_ILLEGAL_INSTR : cause used when an xRET is not permitted
// ---------------------------------------------------------------------------
package trap_sequencer_pkg;

   typedef struct packed {
      logic [1:0] priv;
      logic       mie;
      logic       sie;
      logic       mpie;
      logic       spie;
      logic [1:0] mpp;
      logic       spp;
   } program_state_t;

   typedef enum logic [1:0] {
      TRAP_EXC  = 2'd0,
      TRAP_INT  = 2'd1,
      TRAP_MRET = 2'd2,
      TRAP_SRET = 2'd3
   } trap_kind_t;

   localparam logic [1:0] PRIV_U = 2'd0;
   localparam logic [1:0] PRIV_S = 2'd1;
   localparam logic [1:0] PRIV_M = 2'd3;

   localparam logic [4:0] CAUSE_ILLEGAL_INSTR = 5'd2;

endpackage

// File: rtl/trap_sequencer_target_calc.sv
// ---------------------------------------------------------------------------
// trap_target_calc
// Pure combinational mapping from a latched trap/return request and the
// current program state to everything the sequencer commits in one cycle.
// Ports:
//   i_kind/i_cause/i_pc/i_tval : latched request
//   i_ps                       : current program state
//   i_medeleg/i_mideleg        : delegation masks
//   i_mtvec/i_stvec            : trap vectors, bits[1:0] = mode
//   i_mepc/i_sepc              : return targets
//   o_ps                       : next program state
//   o_redirect_pc              : fetch redirect target
//   o_csr_we/o_csr_to_s        : trap CSR write enable and bank select
//   o_csr_epc/tval/cause       : trap CSR write data
// ---------------------------------------------------------------------------
module trap_target_calc
   import trap_sequencer_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  trap_kind_t        i_kind,
   input  logic [4:0]        i_cause,
   input  logic [ADDR_W-1:0] i_pc,
   input  logic [ADDR_W-1:0] i_tval,
   input  program_state_t    i_ps,
   input  logic [31:0]       i_medeleg,
   input  logic [31:0]       i_mideleg,
   input  logic [ADDR_W-1:0] i_mtvec,
   input  logic [ADDR_W-1:0] i_stvec,
   input  logic [ADDR_W-1:0] i_mepc,
   input  logic [ADDR_W-1:0] i_sepc,
   output program_state_t    o_ps,
   output logic [ADDR_W-1:0] o_redirect_pc,
   output logic              o_csr_we,
   output logic              o_csr_to_s,
   output logic [ADDR_W-1:0] o_csr_epc,
   output logic [ADDR_W-1:0] o_csr_tval,
   output logic [31:0]       o_csr_cause
);

   logic              w_illegal;
   trap_kind_t        w_kind;
   logic [4:0]        w_cause;
   logic [ADDR_W-1:0] w_tval;
   logic              w_is_trap;
   logic              w_deleg_bit;
   logic              w_to_s;
   logic [ADDR_W-1:0] w_tvec;
   logic [ADDR_W-1:0] w_base;
   logic [ADDR_W-1:0] w_trap_pc;

   // An xRET from a privilege that may not execute it becomes an
   // illegal-instruction exception and follows the normal trap path.
   assign w_illegal = ((i_kind == TRAP_MRET) && (i_ps.priv != PRIV_M)) ||
                      ((i_kind == TRAP_SRET) && (i_ps.priv == PRIV_U));
   assign w_kind    = w_illegal ? TRAP_EXC : i_kind;
   assign w_cause   = w_illegal ? CAUSE_ILLEGAL_INSTR : i_cause;
   assign w_tval    = w_illegal ? '0 : i_tval;
   assign w_is_trap = (w_kind == TRAP_EXC) || (w_kind == TRAP_INT);

   assign w_deleg_bit = (w_kind == TRAP_INT) ? i_mideleg[w_cause] : i_medeleg[w_cause];
   assign w_to_s      = w_is_trap && (i_ps.priv != PRIV_M) && w_deleg_bit;

   // Vectored mode only applies to interrupts; exceptions always use base.
   assign w_tvec    = w_to_s ? i_stvec : i_mtvec;
   assign w_base    = {w_tvec[ADDR_W-1:2], 2'b00};
   assign w_trap_pc = ((w_kind == TRAP_INT) && (w_tvec[1:0] == 2'b01)) ?
                      w_base + {{(ADDR_W-7){1'b0}}, w_cause, 2'b00} : w_base;

   always_comb begin
      o_ps          = i_ps;
      o_redirect_pc = '0;
      o_csr_we      = 1'b0;
      o_csr_to_s    = 1'b0;
      o_csr_epc     = '0;
      o_csr_tval    = '0;
      o_csr_cause   = '0;
      if (w_is_trap) begin
         o_redirect_pc = w_trap_pc;
         o_csr_we      = 1'b1;
         o_csr_to_s    = w_to_s;
         o_csr_epc     = i_pc;
         o_csr_tval    = w_tval;
         o_csr_cause   = {(w_kind == TRAP_INT), 26'b0, w_cause};
         if (w_to_s) begin
            o_ps.priv = PRIV_S;
            o_ps.spp  = i_ps.priv[0];
            o_ps.spie = i_ps.sie;
            o_ps.sie  = 1'b0;
         end else begin
            o_ps.priv = PRIV_M;
            o_ps.mpp  = i_ps.priv;
            o_ps.mpie = i_ps.mie;
            o_ps.mie  = 1'b0;
         end
      end else if (w_kind == TRAP_MRET) begin
         o_redirect_pc = i_mepc;
         o_ps.priv     = i_ps.mpp;
         o_ps.mie      = i_ps.mpie;
         o_ps.mpie     = 1'b1;
         o_ps.mpp      = PRIV_U;
      end else begin
         o_redirect_pc = i_sepc;
         o_ps.priv     = {1'b0, i_ps.spp};
         o_ps.sie      = i_ps.spie;
         o_ps.spie     = 1'b1;
         o_ps.spp      = 1'b0;
      end
   end

endmodule

// File: rtl/trap_sequencer.sv
// ---------------------------------------------------------------------------
// trap_sequencer
// Accepts one trap / trap-return request from commit, drains the pipeline,
// then in a single COMMIT cycle updates program state, redirects fetch and
// writes the trap CSRs.
// Ports:
//   i_clk, i_rst               : clock, async active-high reset
//   i_req_valid/o_req_ready    : request handshake
//   i_req_kind/cause/pc/tval   : request payload
//   i_ps                       : current program state
//   i_medeleg/i_mideleg        : delegation masks
//   i_mtvec/i_stvec            : trap vectors
//   i_mepc/i_sepc              : return targets
//   i_drained                  : pipeline empty
//   o_flush                    : kill younger instructions / stall fetch
//   o_alter, o_ps              : program state update strobe and value
//   o_redirect_valid/_pc       : fetch redirect
//   o_csr_*                    : trap CSR write port
// ---------------------------------------------------------------------------
module trap_sequencer
   import trap_sequencer_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  trap_kind_t        i_req_kind,
   input  logic [4:0]        i_req_cause,
   input  logic [ADDR_W-1:0] i_req_pc,
   input  logic [ADDR_W-1:0] i_req_tval,
   input  program_state_t    i_ps,
   input  logic [31:0]       i_medeleg,
   input  logic [31:0]       i_mideleg,
   input  logic [ADDR_W-1:0] i_mtvec,
   input  logic [ADDR_W-1:0] i_stvec,
   input  logic [ADDR_W-1:0] i_mepc,
   input  logic [ADDR_W-1:0] i_sepc,
   input  logic              i_drained,
   output logic              o_flush,
   output logic              o_alter,
   output program_state_t    o_ps,
   output logic              o_redirect_valid,
   output logic [ADDR_W-1:0] o_redirect_pc,
   output logic              o_csr_we,
   output logic              o_csr_to_s,
   output logic [ADDR_W-1:0] o_csr_epc,
   output logic [ADDR_W-1:0] o_csr_tval,
   output logic [31:0]       o_csr_cause
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FLUSH  = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_accept;
   logic              w_commit;

   trap_kind_t        r_kind;
   logic [4:0]        r_cause;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_tval;

   program_state_t    w_ps;
   logic [ADDR_W-1:0] w_redirect_pc;
   logic              w_csr_we;
   logic              w_csr_to_s;
   logic [ADDR_W-1:0] w_csr_epc;
   logic [ADDR_W-1:0] w_csr_tval;
   logic [31:0]       w_csr_cause;

   assign w_accept = (r_state == ST_IDLE) && i_req_valid;
   assign w_commit = (r_state == ST_COMMIT);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Payload needs no reset: it is only consumed in COMMIT, which can only
   // be reached through an accept that reloads it.
   always_ff @(posedge i_clk) begin
      if (w_accept) begin
         r_kind  <= i_req_kind;
         r_cause <= i_req_cause;
         r_pc    <= i_req_pc;
         r_tval  <= i_req_tval;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      o_req_ready = 1'b0;
      o_flush     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            o_req_ready = 1'b1;
            if (i_req_valid) w_state_nxt = ST_FLUSH;
         end
         ST_FLUSH: begin
            o_flush = 1'b1;
            if (i_drained) w_state_nxt = ST_COMMIT;
         end
         ST_COMMIT: begin
            o_flush     = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   trap_target_calc #(.ADDR_W(ADDR_W)) u_calc (
      .i_kind        (r_kind),
      .i_cause       (r_cause),
      .i_pc          (r_pc),
      .i_tval        (r_tval),
      .i_ps          (i_ps),
      .i_medeleg     (i_medeleg),
      .i_mideleg     (i_mideleg),
      .i_mtvec       (i_mtvec),
      .i_stvec       (i_stvec),
      .i_mepc        (i_mepc),
      .i_sepc        (i_sepc),
      .o_ps          (w_ps),
      .o_redirect_pc (w_redirect_pc),
      .o_csr_we      (w_csr_we),
      .o_csr_to_s    (w_csr_to_s),
      .o_csr_epc     (w_csr_epc),
      .o_csr_tval    (w_csr_tval),
      .o_csr_cause   (w_csr_cause)
   );

   // Every commit-side output is forced to zero outside COMMIT.
   assign o_alter          = w_commit;
   assign o_redirect_valid = w_commit;
   assign o_ps             = w_commit ? w_ps          : '0;
   assign o_redirect_pc    = w_commit ? w_redirect_pc : '0;
   assign o_csr_we         = w_commit & w_csr_we;
   assign o_csr_to_s       = w_commit & w_csr_to_s;
   assign o_csr_epc        = w_commit ? w_csr_epc     : '0;
   assign o_csr_tval       = w_commit ? w_csr_tval    : '0;
   assign o_csr_cause      = w_commit ? w_csr_cause   : '0;

endmodule

// File: tb/tb_trap_sequencer.sv
module tb_trap_sequencer;
   import trap_sequencer_pkg::*;

   localparam int ADDR_W = 32;

   logic              clk;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   trap_kind_t        req_kind;
   logic [4:0]        req_cause;
   logic [ADDR_W-1:0] req_pc;
   logic [ADDR_W-1:0] req_tval;
   program_state_t    ps_in;
   logic [31:0]       medeleg;
   logic [31:0]       mideleg;
   logic [ADDR_W-1:0] mtvec;
   logic [ADDR_W-1:0] stvec;
   logic [ADDR_W-1:0] mepc;
   logic [ADDR_W-1:0] sepc;
   logic              drained;
   logic              flush;
   logic              alter;
   program_state_t    ps_out;
   logic              redir_valid;
   logic [ADDR_W-1:0] redir_pc;
   logic              csr_we;
   logic              csr_to_s;
   logic [ADDR_W-1:0] csr_epc;
   logic [ADDR_W-1:0] csr_tval;
   logic [31:0]       csr_cause;

   int n_checks = 0;
   int n_errors = 0;

   trap_sequencer #(.ADDR_W(ADDR_W)) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_req_valid      (req_valid),
      .o_req_ready      (req_ready),
      .i_req_kind       (req_kind),
      .i_req_cause      (req_cause),
      .i_req_pc         (req_pc),
      .i_req_tval       (req_tval),
      .i_ps             (ps_in),
      .i_medeleg        (medeleg),
      .i_mideleg        (mideleg),
      .i_mtvec          (mtvec),
      .i_stvec          (stvec),
      .i_mepc           (mepc),
      .i_sepc           (sepc),
      .i_drained        (drained),
      .o_flush          (flush),
      .o_alter          (alter),
      .o_ps             (ps_out),
      .o_redirect_valid (redir_valid),
      .o_redirect_pc    (redir_pc),
      .o_csr_we         (csr_we),
      .o_csr_to_s       (csr_to_s),
      .o_csr_epc        (csr_epc),
      .o_csr_tval       (csr_tval),
      .o_csr_cause      (csr_cause)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h want %0h", tag, act, exp);
      end
   endtask

   // Presents one request, walks the FLUSH phase (drained rises on FLUSH
   // cycle d, counting from 0) and returns at the negedge inside COMMIT.
   task automatic do_req(input string tag, input trap_kind_t k, input logic [4:0] c,
                         input logic [31:0] pc, input logic [31:0] tv, input int d);
      @(negedge clk);
      chk({tag, "_idle_ready"}, req_ready, 1);
      req_valid = 1'b1;
      req_kind  = k;
      req_cause = c;
      req_pc    = pc;
      req_tval  = tv;
      drained   = (d == 0);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_kind  = TRAP_SRET;
      req_cause = 5'h1f;
      req_pc    = 32'hFFFF_FFF0;
      req_tval  = 32'hFFFF_FFF0;
      for (int i = 0; i <= d; i++) begin
         @(negedge clk);
         chk({tag, "_flush"}, {flush, req_ready, alter}, 3'b100);
         drained = (i >= d);
      end
      @(negedge clk);
      chk({tag, "_commit"}, {alter, redir_valid, flush, req_ready}, 4'b1110);
      drained = 1'b0;
   endtask

   task automatic after_commit(input string tag);
      @(negedge clk);
      chk({tag, "_post"}, {req_ready, alter, redir_valid, csr_we, flush}, 5'b10000);
      chk({tag, "_post_ps"}, ps_out, 0);
   endtask

   program_state_t exp_ps;
   int alter_seen;

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_kind  = TRAP_EXC;
      req_cause = '0;
      req_pc    = '0;
      req_tval  = '0;
      ps_in     = '0;
      medeleg   = '0;
      mideleg   = '0;
      mtvec     = '0;
      stvec     = '0;
      mepc      = '0;
      sepc      = '0;
      drained   = 1'b0;

      // reset state
      #12;
      chk("rst_ready", req_ready, 1);
      chk("rst_ctrl", {flush, alter, redir_valid, csr_we, csr_to_s}, 0);
      chk("rst_ps", ps_out, 0);
      chk("rst_data", {redir_pc, csr_epc}, 0);
      @(negedge clk);
      rst = 1'b0;

      // U-mode exception, no delegation, drained on third FLUSH cycle
      ps_in = '0;
      mtvec = 32'h8000_0100;
      do_req("exc_u", TRAP_EXC, 5'd8, 32'h100, 32'h55, 2);
      exp_ps = '0;
      exp_ps.priv = PRIV_M;
      chk("exc_u_ps", ps_out, exp_ps);
      chk("exc_u_pc", redir_pc, 32'h8000_0100);
      chk("exc_u_cause", csr_cause, 32'h8);
      chk("exc_u_epc", csr_epc, 32'h100);
      chk("exc_u_tval", csr_tval, 32'h55);
      chk("exc_u_we_tos", {csr_we, csr_to_s}, 2'b10);
      after_commit("exc_u");

      // vectored interrupt from M, drained immediately
      ps_in = '0;
      ps_in.priv = PRIV_M;
      ps_in.mie  = 1'b1;
      mtvec = 32'h8000_0001;
      do_req("int_m", TRAP_INT, 5'd7, 32'h200, 32'h0, 0);
      exp_ps = '0;
      exp_ps.priv = PRIV_M;
      exp_ps.mpp  = PRIV_M;
      exp_ps.mpie = 1'b1;
      chk("int_m_ps", ps_out, exp_ps);
      chk("int_m_pc", redir_pc, 32'h8000_001C);
      chk("int_m_cause", csr_cause, 32'h8000_0007);
      chk("int_m_we_tos", {csr_we, csr_to_s}, 2'b10);
      after_commit("int_m");

      // delegated U-mode exception to S
      ps_in = '0;
      ps_in.sie = 1'b1;
      medeleg = 32'h0000_0100;
      stvec = 32'h1000;
      mtvec = 32'h8000_0100;
      do_req("exc_s", TRAP_EXC, 5'd8, 32'h140, 32'h0, 0);
      exp_ps = '0;
      exp_ps.priv = PRIV_S;
      exp_ps.spie = 1'b1;
      chk("exc_s_ps", ps_out, exp_ps);
      chk("exc_s_pc", redir_pc, 32'h1000);
      chk("exc_s_we_tos", {csr_we, csr_to_s}, 2'b11);
      chk("exc_s_cause", csr_cause, 32'h8);
      after_commit("exc_s");

      // MRET in M returning to S
      medeleg = '0;
      ps_in = '0;
      ps_in.priv = PRIV_M;
      ps_in.mpp  = PRIV_S;
      ps_in.mpie = 1'b1;
      mepc = 32'h2000;
      do_req("mret", TRAP_MRET, 5'd0, 32'h180, 32'h0, 1);
      exp_ps = '0;
      exp_ps.priv = PRIV_S;
      exp_ps.mie  = 1'b1;
      exp_ps.mpie = 1'b1;
      exp_ps.mpp  = PRIV_U;
      chk("mret_ps", ps_out, exp_ps);
      chk("mret_pc", redir_pc, 32'h2000);
      chk("mret_we", csr_we, 0);
      after_commit("mret");

      // MRET from S is illegal: traps to M with cause 2, tval 0
      ps_in = '0;
      ps_in.priv = PRIV_S;
      ps_in.mie  = 1'b1;
      mtvec = 32'h4000;
      do_req("mret_ill", TRAP_MRET, 5'd0, 32'h300, 32'hDEAD, 0);
      exp_ps = '0;
      exp_ps.priv = PRIV_M;
      exp_ps.mpp  = PRIV_S;
      exp_ps.mpie = 1'b1;
      chk("mret_ill_ps", ps_out, exp_ps);
      chk("mret_ill_cause", csr_cause, 32'h2);
      chk("mret_ill_tval", csr_tval, 32'h0);
      chk("mret_ill_epc", csr_epc, 32'h300);
      chk("mret_ill_pc", redir_pc, 32'h4000);
      chk("mret_ill_we", {csr_we, csr_to_s}, 2'b10);
      after_commit("mret_ill");

      // SRET in S returning to U
      ps_in = '0;
      ps_in.priv = PRIV_S;
      ps_in.spie = 1'b1;
      sepc = 32'h3000;
      do_req("sret", TRAP_SRET, 5'd0, 32'h340, 32'h0, 0);
      exp_ps = '0;
      exp_ps.priv = PRIV_U;
      exp_ps.sie  = 1'b1;
      exp_ps.spie = 1'b1;
      chk("sret_ps", ps_out, exp_ps);
      chk("sret_pc", redir_pc, 32'h3000);
      chk("sret_we", csr_we, 0);
      after_commit("sret");

      // back-to-back with valid held high
      ps_in = '0;
      ps_in.priv = PRIV_M;
      mtvec = 32'h5000;
      @(negedge clk);
      req_valid = 1'b1;
      req_kind  = TRAP_EXC;
      req_cause = 5'd11;
      req_pc    = 32'h400;
      drained   = 1'b1;
      chk("b2b_acc1", req_ready, 1);
      @(negedge clk);
      chk("b2b_flush1", {req_ready, flush, alter}, 3'b010);
      @(negedge clk);
      chk("b2b_commit1", {req_ready, alter}, 2'b01);
      chk("b2b_pc1", redir_pc, 32'h5000);
      @(negedge clk);
      chk("b2b_acc2", {req_ready, alter, flush}, 3'b100);
      @(negedge clk);
      chk("b2b_flush2", {req_ready, flush, alter}, 3'b010);
      req_valid = 1'b0;
      @(negedge clk);
      chk("b2b_commit2", {req_ready, alter}, 2'b01);
      chk("b2b_cause2", csr_cause, 32'd11);
      drained = 1'b0;
      after_commit("b2b");

      // reset pulse during FLUSH discards the request
      @(negedge clk);
      req_valid = 1'b1;
      req_kind  = TRAP_EXC;
      req_cause = 5'd3;
      @(negedge clk);
      req_valid = 1'b0;
      chk("rstf_in_flush", {flush, req_ready}, 2'b10);
      drained = 1'b1;
      #1;
      rst = 1'b1;
      #1;
      chk("rstf_during", {req_ready, flush, alter}, 3'b100);
      @(negedge clk);
      rst = 1'b0;
      alter_seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (alter) alter_seen++;
      end
      chk("rstf_no_alter", alter_seen, 0);
      chk("rstf_ready", req_ready, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
